// File: rtl/hkspi_master.sv
// Housekeeping-SPI master: frames CSB, shifts a command byte, an address byte and
// a stream of data bytes (mode 0, MSB first) between a request/data handshake and the SPI pins.
module hkspi_master #(
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [7:0]       req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [7:0]       wdata,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  output logic [7:0]       rdata,
  output logic             rdata_valid,
  output logic             busy,
  output logic             done,
  output logic             spi_csb,
  output logic             spi_sck,
  output logic             spi_sdi,
  input  logic             spi_sdo
);

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] CMD_WRITE = 8'h80;
  localparam logic [7:0] CMD_READ  = 8'h40;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_ADDR, S_DATA, S_STALL, S_HOLD, S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       tx_q, tx_d, rx_q, rx_d, addr_q, addr_d, rdata_d;
  logic             write_q, write_d;
  logic             csb_d, sck_d, sdi_d, rvalid_d, done_d;
  logic             div_last, start_data, take_wdata;

  assign div_last    = (div_q == DIV_LAST);
  assign wdata_ready = take_wdata & ~reset;

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q + 8'd1;
    bit_d      = bit_q;
    len_d      = len_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    addr_d     = addr_q;
    write_d    = write_q;
    csb_d      = spi_csb;
    sck_d      = spi_sck;
    sdi_d      = spi_sdi;
    rdata_d    = rdata;
    rvalid_d   = 1'b0;
    done_d     = 1'b0;
    start_data = 1'b0;
    take_wdata = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (req_valid && req_ready) begin
          state_d = S_SETUP;
          csb_d   = 1'b0;
          write_d = req_write;
          addr_d  = req_addr;
          len_d   = req_len;
        end
      end
      S_SETUP: begin
        if (div_last) begin
          state_d = S_CMD;
          div_d   = '0;
          bit_d   = '0;
          tx_d    = write_q ? CMD_WRITE : CMD_READ;
          sdi_d   = write_q;
        end
      end
      S_CMD, S_ADDR, S_DATA: begin
        if (div_last) begin
          div_d = '0;
          if (!spi_sck) begin
            // End of low phase: raise SCK and sample SDO on the same edge.
            sck_d = 1'b1;
            rx_d  = {rx_q[6:0], spi_sdo};
            if (state_q == S_DATA && !write_q && bit_q == 3'd7) begin
              rdata_d  = rx_d;
              rvalid_d = 1'b1;
            end
          end else begin
            sck_d = 1'b0;
            if (bit_q != 3'd7) begin
              bit_d = bit_q + 3'd1;
              tx_d  = {tx_q[6:0], 1'b0};
              sdi_d = tx_q[6];
            end else if (state_q == S_CMD) begin
              state_d = S_ADDR;
              bit_d   = '0;
              tx_d    = addr_q;
              sdi_d   = addr_q[7];
            end else if (state_q == S_ADDR || len_q != '0) begin
              start_data = 1'b1;
              if (state_q == S_DATA) len_d = len_q - LEN_W'(1);
            end else begin
              state_d = S_HOLD;
              sdi_d   = 1'b0;
            end
          end
        end
      end
      S_STALL: start_data = 1'b1;
      S_HOLD: begin
        if (div_last) begin
          state_d = S_GAP;
          div_d   = '0;
          csb_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (div_last) begin
          state_d = S_IDLE;
          div_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A data byte starts at the boundary of the previous byte, or waits with SCK low.
    if (start_data) begin
      state_d = S_DATA;
      bit_d   = '0;
      div_d   = '0;
      tx_d    = '0;
      sdi_d   = 1'b0;
      if (write_q) begin
        if (wdata_valid) begin
          take_wdata = 1'b1;
          tx_d       = wdata;
          sdi_d      = wdata[7];
        end else begin
          state_d = S_STALL;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      len_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      spi_csb     <= 1'b1;
      spi_sck     <= 1'b0;
      spi_sdi     <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      req_ready   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      len_q       <= len_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      spi_csb     <= csb_d;
      spi_sck     <= sck_d;
      spi_sdi     <= sdi_d;
      rdata       <= rdata_d;
      rdata_valid <= rvalid_d;
      done        <= done_d;
      busy        <= (state_d != S_IDLE);
      req_ready   <= (state_d == S_IDLE);
    end
  end

endmodule

// File: tb/tb_hkspi_master.sv
// Directed bench for hkspi_master (CLK_DIV=2): a mode-0 slave model with a small
// register map, pin-level monitors, and hand-computed frame lengths and byte sequences.
module tb_hkspi_master;

  localparam int CLK_DIV = 2;
  localparam logic [7:0] MAP [19] = '{8'h00, 8'h04, 8'h56, 8'h11, 8'h00, 8'h00, 8'h00,
                                      8'h00, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'hff,
                                      8'hef, 8'hff, 8'h03, 8'h12, 8'h04};

  logic       clock = 1'b0;
  logic       reset, req_valid, req_ready, req_write, wdata_valid, wdata_ready;
  logic [7:0] req_addr, wdata, rdata;
  logic [4:0] req_len;
  logic       rdata_valid, busy, done, spi_csb, spi_sck, spi_sdi;
  logic       spi_sdo = 1'b0;

  int checks = 0, failures = 0;

  hkspi_master #(.CLK_DIV(CLK_DIV), .LEN_W(5)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done),
    .spi_csb(spi_csb), .spi_sck(spi_sck), .spi_sdi(spi_sdi), .spi_sdo(spi_sdo)
  );

  always #5 clock = ~clock;

  // Slave: captures SDI on SCK rise, drives SDO from the map on SCK fall after 16 bits.
  int         bitn = 0;
  int         sk;
  logic [7:0] srx = '0, saddr = '0, sv;
  logic [7:0] slave_bytes [$];

  function automatic logic [7:0] map_byte(input logic [7:0] a);
    int i = int'(a);
    return (i < 19) ? MAP[i] : 8'h00;
  endfunction

  always @(posedge spi_sck or negedge spi_sck or posedge spi_csb) begin
    if (spi_csb !== 1'b0) begin
      bitn    = 0;
      spi_sdo = 1'b0;
    end else if (spi_sck === 1'b1) begin
      srx = {srx[6:0], spi_sdi};
      bitn++;
      if (bitn % 8 == 0) slave_bytes.push_back(srx);
      if (bitn == 16) saddr = srx;
    end else if (bitn >= 16) begin
      sk      = bitn - 16;
      sv      = map_byte(saddr + 8'(sk / 8));
      spi_sdo = sv[7 - (sk % 8)];
    end
  end

  // Pin monitor, sampled on the falling system-clock edge.
  int   cyc = 0, low_run = 0, high_run = 0, last_low = 0, last_gap = 0;
  int   done_cnt = 0, done_bad = 0, wready_cnt = 0;
  int   acc_cnt = 0, acc_bad = 0, last_acc = 0, prev_acc = 0;
  logic csb_prev = 1'b1;
  logic [7:0] rq [$];

  always @(negedge clock) begin
    cyc++;
    if (spi_csb === 1'b0) begin
      if (csb_prev) last_gap = high_run;
      high_run = 0;
      low_run++;
    end else begin
      if (!csb_prev) last_low = low_run;
      low_run = 0;
      high_run++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (!(spi_csb === 1'b1 && !csb_prev)) done_bad++;
    end
    if (rdata_valid === 1'b1) rq.push_back(rdata);
    if (wdata_ready === 1'b1) wready_cnt++;
    if (req_valid && req_ready === 1'b1) begin
      acc_cnt++;
      prev_acc = last_acc;
      last_acc = cyc;
      if (busy !== 1'b0 || spi_csb !== 1'b1) acc_bad++;
    end
    csb_prev = (spi_csb !== 1'b0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] sb_at(input int i);
    return (i < slave_bytes.size()) ? slave_bytes[i] : 8'hxx;
  endfunction

  function automatic logic [7:0] rq_at(input int i);
    return (i < rq.size()) ? rq[i] : 8'hxx;
  endfunction

  task automatic issue(input logic wr, input logic [7:0] addr, input logic [4:0] len);
    int n = 0;
    while (req_ready !== 1'b1 && n < 200) begin tick(); n++; end
    check("issue_ready", req_ready, 1);
    req_write = wr;
    req_addr  = addr;
    req_len   = len;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target);
    int n = 0;
    while (done_cnt < target && n < 3000) begin tick(); n++; end
    check({tag, "_done"}, 32'(done_cnt >= target), 1);
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin tick(); n++; end
    check({tag, "_idle"}, req_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int sb, rb, d0, w0, a0, n, stall_bad;
  logic [7:0] exp2 [6] = '{8'h80, 8'h0b, 8'h01, 8'h80, 8'h0b, 8'h00};

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wdata = '0; wdata_valid = 1'b0;
    repeat (3) tick();
    check("rst_csb", spi_csb, 1);
    check("rst_sck", spi_sck, 0);
    check("rst_sdi", spi_sdi, 0);
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wready", wdata_ready, 0);
    check("rst_rvalid", rdata_valid, 0);
    check("rst_rdata", rdata, 0);
    reset = 1'b0;
    tick();
    check("rst_ready_after", req_ready, 1);

    // Single-byte read of 0x03.
    sb = slave_bytes.size(); rb = rq.size(); d0 = done_cnt;
    issue(1'b0, 8'h03, 5'd0);
    wait_done("t1", d0 + 1);
    check("t1_cmd", sb_at(sb), 8'h40);
    check("t1_addr", sb_at(sb + 1), 8'h03);
    check("t1_sdi_data", sb_at(sb + 2), 8'h00);
    check("t1_nread", rq.size() - rb, 1);
    check("t1_rdata", rq_at(rb), 8'h11);
    check("t1_csb_low", last_low, 100);
    check("t1_done_edge", done_bad, 0);

    // Read stream of 19 bytes from 0x00.
    rb = rq.size(); d0 = done_cnt;
    issue(1'b0, 8'h00, 5'd18);
    wait_done("t3", d0 + 1);
    check("t3_nread", rq.size() - rb, 19);
    for (int i = 0; i < 19; i++) check($sformatf("t3_byte%0d", i), rq_at(rb + i), MAP[i]);
    check("t3_csb_low", last_low, 676);

    // Two back-to-back single-byte writes to 0x0b.
    sb = slave_bytes.size(); d0 = done_cnt; w0 = wready_cnt;
    wdata = 8'h01; wdata_valid = 1'b1;
    issue(1'b1, 8'h0b, 5'd0);
    wait_done("t2a", d0 + 1);
    wdata_valid = 1'b0;
    check("t2_csb_low", last_low, 100);
    wdata = 8'h00; wdata_valid = 1'b1;
    issue(1'b1, 8'h0b, 5'd0);
    wait_done("t2b", d0 + 2);
    wdata_valid = 1'b0;
    for (int i = 0; i < 6; i++) check($sformatf("t2_byte%0d", i), sb_at(sb + i), exp2[i]);
    check("t2_wready", wready_cnt - w0, 2);
    check("t2_gap", 32'(last_gap >= CLK_DIV), 1);

    // Two-byte write, first unstalled, then with the second byte withheld 37 cycles.
    d0 = done_cnt; w0 = wready_cnt;
    wdata = 8'ha5; wdata_valid = 1'b1;
    issue(1'b1, 8'h20, 5'd1);
    wait_done("t4a", d0 + 1);
    wdata_valid = 1'b0;
    check("t4_base_low", last_low, 132);
    check("t4_base_wready", wready_cnt - w0, 2);

    sb = slave_bytes.size(); d0 = done_cnt; w0 = wready_cnt;
    wdata = 8'ha5; wdata_valid = 1'b1;
    issue(1'b1, 8'h20, 5'd1);
    n = 0;
    while (wdata_ready !== 1'b1 && n < 200) begin tick(); n++; end
    check("t4_first_take", wdata_ready, 1);
    tick();
    wdata_valid = 1'b0; wdata = 8'h5a; stall_bad = 0;
    for (int i = 1; i <= 68; i++) begin
      tick();
      if (i >= 32 && (spi_sck !== 1'b0 || spi_csb !== 1'b0)) stall_bad++;
    end
    wdata_valid = 1'b1;
    #1;
    check("t4_stall_take", wdata_ready, 1);
    tick();
    wdata_valid = 1'b0;
    wait_done("t4b", d0 + 1);
    check("t4_stall_pins", stall_bad, 0);
    check("t4_stall_low", last_low, 169);
    check("t4_stall_wready", wready_cnt - w0, 2);
    check("t4_byte0", sb_at(sb + 2), 8'ha5);
    check("t4_byte1", sb_at(sb + 3), 8'h5a);

    // Reset in the middle of the address byte, then a clean read.
    d0 = done_cnt; rb = rq.size();
    issue(1'b0, 8'h03, 5'd0);
    n = 0;
    while (bitn < 10 && n < 200) begin tick(); n++; end
    check("t5_mid_addr", 32'(bitn >= 10), 1);
    reset = 1'b1;
    tick();
    check("t5_csb", spi_csb, 1);
    check("t5_sck", spi_sck, 0);
    check("t5_busy", busy, 0);
    check("t5_ready_in_rst", req_ready, 0);
    reset = 1'b0;
    tick();
    check("t5_ready", req_ready, 1);
    repeat (5) tick();
    check("t5_no_done", done_cnt - d0, 0);
    check("t5_no_rvalid", rq.size() - rb, 0);
    issue(1'b0, 8'h03, 5'd0);
    wait_done("t5", d0 + 1);
    check("t5_nread", rq.size() - rb, 1);
    check("t5_rdata", rq_at(rb), 8'h11);

    // req_valid held for 150 cycles: accepts only at IDLE, 103 cycles apart.
    d0 = done_cnt; a0 = acc_cnt; rb = rq.size();
    req_write = 1'b0; req_addr = 8'h03; req_len = 5'd0;
    req_valid = 1'b1;
    repeat (150) tick();
    req_valid = 1'b0;
    wait_done("t6", d0 + 2);
    check("t6_accepts", acc_cnt - a0, 2);
    check("t6_spacing", last_acc - prev_acc, 103);
    check("t6_acc_busy", acc_bad, 0);
    check("t6_gap", 32'(last_gap >= CLK_DIV), 1);
    check("t6_rdata0", rq_at(rb), 8'h11);
    check("t6_rdata1", rq_at(rb + 1), 8'h11);
    check("t6_done_edge", done_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hkspi_master.md
Name: hkspi_master

Overview:
- Synchronous SPI master that sequences housekeeping-SPI register transactions: CSB framing, command byte, address byte, then a streamed run of data bytes.
- Lets on-chip logic or test firmware reproduce the external read-stream / write-stream protocol without a pin-level bench.
- Sits between a simple request/data handshake interface and the four housekeeping pins (SCK, CSB, SDI, SDO).

Parameters:
- CLK_DIV, 4: system clocks per SCK half-period; legal range 2..255.
- LEN_W, 5: width of the byte-count field; max stream length is 2^LEN_W bytes.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  transaction request.
- req_ready  out  1  master idle and able to accept a request.
- req_write  in  1  1 = write stream (cmd 0x80), 0 = read stream (cmd 0x40).
- req_addr  in  8  start register address.
- req_len  in  LEN_W  number of data bytes minus 1.
- wdata  in  8  write byte.
- wdata_valid  in  1  write byte available.
- wdata_ready  out  1  write byte consumed this cycle.
- rdata  out  8  read byte.
- rdata_valid  out  1  one-cycle pulse per read byte; no backpressure.
- busy  out  1  high from accept to end of GAP.
- done  out  1  one-cycle pulse when CSB deasserts.
- spi_csb  out  1  chip select, active low.
- spi_sck  out  1  serial clock, idle low.
- spi_sdi  out  1  master-to-slave data.
- spi_sdo  in  1  slave-to-master data.

Behaviour:
- Reset values: spi_csb=1, spi_sck=0, spi_sdi=0, req_ready=0 during reset and 1 the cycle after, busy=0, done=0, wdata_ready=0, rdata_valid=0, rdata=0.
- Reset mid-transaction aborts immediately: CSB=1 and SCK=0 on the next edge. No done pulse, no further rdata_valid.
- Accept on req_valid && req_ready. Latch req_write, req_addr, req_len. req_ready drops the next cycle.
- State machine: IDLE -> SETUP -> CMD -> ADDR -> DATA -> HOLD -> GAP -> IDLE.
- SETUP: CSB low the cycle after accept, SCK low for CLK_DIV cycles.
- Bit timing, MSB first:
  - Low phase: CLK_DIV cycles, SDI updated on its first cycle.
  - High phase: CLK_DIV cycles, SCK=1.
  - spi_sdo is sampled on the clock edge that raises SCK.
  - One byte takes 16*CLK_DIV cycles.
- CMD shifts 0x80 or 0x40. ADDR shifts req_addr.
- DATA, write:
  - Before each data byte, in SCK-low state, wait for wdata_valid.
  - wdata_ready pulses for one cycle on the consuming cycle, and the byte's first bit starts the next cycle.
  - Stall length is unbounded; SCK holds low and CSB holds low throughout.
- DATA, read:
  - SDI driven 0.
  - rdata_valid pulses the cycle after the 8th sample, with rdata = assembled byte.
- DATA runs req_len+1 bytes. A down-counter of LEN_W bits terminates at 0; there is no wrap.
- HOLD: SCK low, CSB low for CLK_DIV cycles. Then CSB=1 and done=1 on the same cycle.
- GAP: CSB high for CLK_DIV cycles. req_ready returns high the cycle after GAP ends; busy falls the same cycle.
- Unstalled CSB-low duration: (2 + 16*(req_len+3))*CLK_DIV cycles.
- req_valid while busy is ignored and not queued. Inputs are sampled only at accept, and wdata only when wdata_ready=1.
- spi_sdi, spi_sck and spi_csb are registered outputs with no combinational path from inputs.

Test Plan:
- Read, CLK_DIV=2, addr 0x03, req_len=0, slave model returns 0x11:
  - SDI shows 0x40 then 0x03.
  - rdata_valid pulses once with rdata=0x11.
  - CSB is low exactly 100 cycles; done pulses on CSB rise.
- Write stream, addr 0x0b, req_len=0, data 0x01, then a second request with data 0x00:
  - Slave model sees 0x80,0x0b,0x01 and then 0x80,0x0b,0x00.
  - Gap between transactions is at least CLK_DIV cycles with CSB high.
- Read stream from addr 0x00, req_len=18, model holds the register map:
  - 19 rdata_valid pulses: 0x00,0x04,0x56,0x11,0x00,0x00,0x00,0x00,0x02,0x01,0x00,0x00,0x00,0xff,0xef,0xff,0x03,0x12,0x04.
- Write with wdata_valid withheld 37 cycles before the 2nd byte:
  - SCK stays low and CSB stays low during the stall.
  - wdata_ready pulses exactly twice.
  - CSB-low duration grows by exactly 37 cycles.
- Reset asserted mid-ADDR byte:
  - Next cycle CSB=1, SCK=0, busy=0, no done pulse.
  - req_ready=1 one cycle after reset drops.
  - A fresh read of 0x03 then returns 0x11.
- req_valid held high throughout a transaction:
  - Exactly one accept per transaction.
  - Next accept occurs only after GAP, with no overlapping CSB-low windows.
